// File: rtl/seq_lock_pkg.sv
// rtl/seq_lock_pkg.sv - shared state encoding and key-vector helpers for seq_lock_ctrl
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROGRAM  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  localparam int KEY_VEC_W = 32;

  function automatic logic is_onehot(input logic [KEY_VEC_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [4:0] onehot_index(input logic [KEY_VEC_W-1:0] v);
    logic [4:0] r_idx;
    r_idx = '0;
    for (int i = 0; i < KEY_VEC_W; i++) begin
      if (v[i]) r_idx = i[4:0];
    end
    return r_idx;
  endfunction

endpackage

// File: rtl/seq_lock_key_event.sv
// rtl/seq_lock_key_event.sv - TICK-qualified key press / bad / change detection
module seq_lock_key_event
  import seq_lock_pkg::*;
#(
  parameter  int NUM_KEYS = 2,
  localparam int KW       = $clog2(NUM_KEYS)
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                TICK,
  input  logic [NUM_KEYS-1:0] KEYS,
  output logic                o_press,
  output logic [KW-1:0]       o_press_key,
  output logic                o_bad,
  output logic                o_change
);

  logic [NUM_KEYS-1:0] r_prev_keys;
  logic                w_onehot;
  logic                w_from_idle;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_prev_keys <= '0;
    end else if (TICK) begin
      r_prev_keys <= KEYS;
    end
  end

  assign w_onehot    = is_onehot(KEY_VEC_W'(KEYS));
  assign w_from_idle = (r_prev_keys == '0);
  assign o_press_key = KW'(onehot_index(KEY_VEC_W'(KEYS)));

  // A press needs a fully released keypad before it; anything else new is bad.
  assign o_press  = TICK && w_from_idle && w_onehot;
  assign o_change = TICK && (KEYS != r_prev_keys);
  assign o_bad    = o_change && (KEYS != '0) && !(w_from_idle && w_onehot);

endmodule

// File: rtl/seq_lock_ctrl.sv
// rtl/seq_lock_ctrl.sv - sequence lock FSM with lockout, code programming and debug view
module seq_lock_ctrl
  import seq_lock_pkg::*;
#(
  parameter  int                              NUM_KEYS      = 2,
  parameter  int                              SEQ_LEN       = 5,
  parameter  logic [SEQ_LEN*$clog2(NUM_KEYS)-1:0] DEFAULT_CODE = 5'b01101,
  parameter  int                              MAX_FAILS     = 3,
  parameter  int                              LOCKOUT_TICKS = 10,
  parameter  int                              STATE_VIEW    = 0,
  localparam int                              KW            = $clog2(NUM_KEYS),
  localparam int                              IW            = $clog2(SEQ_LEN+1)
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                TICK,
  input  logic [NUM_KEYS-1:0] KEYS,
  input  logic                LOCK,
  input  logic                SET,
  output logic                UNLOCK,
  output logic                GREEN,
  output logic                RED,
  output logic                PROG_ACTIVE,
  output logic [1:0]          oSTATE,
  output logic [IW-1:0]       oIDX
);

  localparam int TW = $clog2(LOCKOUT_TICKS+1);
  localparam int FW = $clog2(MAX_FAILS+1);

  state_t                 r_state;
  logic [IW-1:0]          r_idx;
  logic [FW-1:0]          r_fail_cnt;
  logic [TW-1:0]          r_timer;
  logic [SEQ_LEN*KW-1:0]  r_code;
  logic [SEQ_LEN*KW-1:0]  r_shadow;
  logic                   r_unlock;
  logic                   r_green;
  logic                   r_red;
  logic                   r_prog;

  logic                   w_press;
  logic [KW-1:0]          w_press_key;
  logic                   w_bad;
  logic                   w_change;
  logic [KW-1:0]          w_expect;
  logic                   w_last;
  logic [SEQ_LEN*KW-1:0]  w_shadow_next;

  seq_lock_key_event #(.NUM_KEYS(NUM_KEYS)) u_key_event (
    .CLK         (CLK),
    .nRESET      (nRESET),
    .TICK        (TICK),
    .KEYS        (KEYS),
    .o_press     (w_press),
    .o_press_key (w_press_key),
    .o_bad       (w_bad),
    .o_change    (w_change)
  );

  assign w_expect = r_code[r_idx*KW +: KW];
  assign w_last   = (r_idx == IW'(SEQ_LEN-1));

  // Shadow with the current press merged in, so the final press commits atomically.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_idx*KW +: KW] = w_press_key;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_fail_cnt <= '0;
      r_timer    <= '0;
      r_code     <= DEFAULT_CODE;
      r_shadow   <= '0;
      r_unlock   <= 1'b0;
      r_green    <= 1'b0;
      r_red      <= 1'b0;
      r_prog     <= 1'b0;
    end else if (TICK) begin
      case (r_state)
        ST_IDLE: begin
          if (w_press && (w_press_key == w_expect)) begin
            if (w_last) begin
              r_state    <= ST_UNLOCKED;
              r_idx      <= '0;
              r_fail_cnt <= '0;
              r_unlock   <= 1'b1;
              r_green    <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (w_press || w_bad) begin
            r_idx <= '0;
            if (r_fail_cnt >= FW'(MAX_FAILS-1)) begin
              r_fail_cnt <= FW'(MAX_FAILS);
              r_state    <= ST_LOCKOUT;
              r_timer    <= TW'(LOCKOUT_TICKS);
              r_red      <= 1'b1;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end
        end
        ST_UNLOCKED: begin
          if (LOCK) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_unlock <= 1'b0;
            r_green  <= 1'b0;
          end else if (SET && !w_change) begin
            r_state <= ST_PROGRAM;
            r_idx   <= '0;
            r_green <= 1'b0;
            r_prog  <= 1'b1;
          end else if (w_change) begin
            // GREEN doubles as the "first change not yet seen" flag.
            if (r_green) begin
              r_green <= 1'b0;
            end else begin
              r_state  <= ST_IDLE;
              r_idx    <= '0;
              r_unlock <= 1'b0;
            end
          end
        end
        ST_PROGRAM: begin
          if (LOCK || w_bad) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_unlock <= 1'b0;
            r_prog   <= 1'b0;
          end else if (w_press) begin
            r_shadow <= w_shadow_next;
            if (w_last) begin
              r_code   <= w_shadow_next;
              r_state  <= ST_IDLE;
              r_idx    <= '0;
              r_unlock <= 1'b0;
              r_prog   <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          if (r_timer <= TW'(1)) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_fail_cnt <= '0;
            r_red      <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign UNLOCK      = r_unlock;
  assign GREEN       = r_green;
  assign RED         = r_red;
  assign PROG_ACTIVE = r_prog;
  assign oSTATE      = (STATE_VIEW != 0) ? r_state : 2'b00;
  assign oIDX        = (STATE_VIEW != 0) ? r_idx : '0;

endmodule
